// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake and entry fields for fetch_queue
interface fetch_queue_if #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7
);
  logic             fetchValid;
  logic             fetchReady;
  logic [WIDTH:0]   instr;
  logic [WIDTH:0]   instrPC;
  logic [WIDTH:0]   predictedPCF;
  logic [INDEX:0]   GHRIndex;
  logic [1:0]       PHTState;
  logic             redirect;

  logic             decodeReady;
  logic             decodeValid;
  logic [WIDTH:0]   instrD;
  logic [WIDTH:0]   instrPCD;
  logic [WIDTH:0]   predictedPCD;
  logic [INDEX:0]   GHRIndexD;
  logic [1:0]       PHTStateD;
  logic             redirectD;

  // master: fetch/decode environment; slave: the queue
  modport master (
    output fetchValid, instr, instrPC, predictedPCF, GHRIndex, PHTState, redirect, decodeReady,
    input  fetchReady, decodeValid, instrD, instrPCD, predictedPCD, GHRIndexD, PHTStateD, redirectD
  );

  modport slave (
    input  fetchValid, instr, instrPC, predictedPCF, GHRIndex, PHTState, redirect, decodeReady,
    output fetchReady, decodeValid, instrD, instrPCD, predictedPCD, GHRIndexD, PHTStateD, redirectD
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode FIFO carrying instruction plus branch-prediction context
// Optional empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7,
  parameter int DEPTH = 4,
  parameter int PTR   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          globalReset,
  fetch_queue_if.slave  fq,
  input  logic          flush,
  input  logic          decodeFlush,
  output logic [PTR:0]  occupancy
);

  localparam int           EW      = 3 * (WIDTH + 1) + (INDEX + 1) + 3;
  localparam logic [PTR:0] FULL    = (PTR + 1)'(DEPTH);
  localparam logic [PTR:0] CNT_ONE = (PTR + 1)'(1);
  localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  mem_d [DEPTH];
  logic [PTR-1:0] head_q, head_d;
  logic [PTR-1:0] tail_q, tail_d;
  logic [PTR:0]   count_q, count_d;

  logic           flush_any;
  logic           fetch_ready;
  logic           bypass;
  logic           decode_valid;
  logic           push;
  logic           pop;
  logic [EW-1:0]  in_entry;
  logic [EW-1:0]  head_entry;
  logic [EW-1:0]  out_entry;

  assign in_entry = {fq.redirect, fq.PHTState, fq.GHRIndex, fq.predictedPCF, fq.instrPC, fq.instr};

  always_comb begin
    flush_any   = flush || decodeFlush;
    // Ready depends on registered count only, so a full queue refuses a push even while popping.
    fetch_ready = globalReset && (count_q != FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass      = globalReset && (count_q == '0) && fq.fetchValid && fq.decodeReady && !flush_any;
`else
    bypass      = 1'b0;
`endif
    decode_valid = globalReset && ((count_q != '0) || bypass);
    push         = fq.fetchValid && fetch_ready && !bypass;
    pop          = globalReset && (count_q != '0) && fq.decodeReady;
    head_entry   = bypass ? in_entry : mem_q[head_q];
    out_entry    = decode_valid ? head_entry : '0;
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_any) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = in_entry;
        tail_d        = tail_q + PTR_ONE;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!globalReset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; stale data is masked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fq.fetchReady  = fetch_ready;
  assign fq.decodeValid = decode_valid;
  assign {fq.redirectD, fq.PHTStateD, fq.GHRIndexD, fq.predictedPCD, fq.instrPCD, fq.instrD} = out_entry;
  assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic       clk = 1'b0;
  logic       globalReset;
  logic       flush;
  logic       decodeFlush;
  logic [2:0] occupancy;
  int         errors = 0;
  int         checks = 0;

  fetch_queue_if #(.WIDTH(31), .INDEX(7)) fi ();

  fetch_queue #(.WIDTH(31), .INDEX(7), .DEPTH(4)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .fq          (fi.slave),
    .flush       (flush),
    .decodeFlush (decodeFlush),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    fi.fetchValid   = v;
    fi.instrPC      = pc;
    fi.instr        = ins;
    fi.predictedPCF = pc + 32'd4;
    fi.GHRIndex     = pc[9:2];
    fi.PHTState     = pc[3:2];
    fi.redirect     = pc[2];
  endtask

  int          pv [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int          rv [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1};
  logic [31:0] mq [$];
  logic [31:0] pc;
  logic        do_push;
  logic        do_pop;
  int          n;

  initial begin
    globalReset    = 1'b0;
    flush          = 1'b0;
    decodeFlush    = 1'b0;
    fi.decodeReady = 1'b0;
    drive_fetch(1'b0, 32'h0, 32'h0);
    step();
    step();
    check_eq("rst_held_fetchReady", fi.fetchReady, 0);
    check_eq("rst_held_decodeValid", fi.decodeValid, 0);
    globalReset = 1'b1;
    #1;
    check_eq("rst_fetchReady", fi.fetchReady, 1);
    check_eq("rst_decodeValid", fi.decodeValid, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_instrD", fi.instrD, 0);

    // single push of A, visible one cycle later
    fi.fetchValid   = 1'b1;
    fi.instr        = 32'h00500093;
    fi.instrPC      = 32'h0;
    fi.predictedPCF = 32'h4;
    fi.GHRIndex     = 8'h5a;
    fi.PHTState     = 2'd2;
    fi.redirect     = 1'b1;
    #1;
    check_eq("a_same_cycle_valid", fi.decodeValid, 0);
    step();
    fi.fetchValid = 1'b0;
    #1;
    check_eq("a_decodeValid", fi.decodeValid, 1);
    check_eq("a_instrD", fi.instrD, 32'h00500093);
    check_eq("a_instrPCD", fi.instrPCD, 32'h0);
    check_eq("a_predictedPCD", fi.predictedPCD, 32'h4);
    check_eq("a_GHRIndexD", fi.GHRIndexD, 8'h5a);
    check_eq("a_PHTStateD", fi.PHTStateD, 2'd2);
    check_eq("a_redirectD", fi.redirectD, 1);
    check_eq("a_occupancy", occupancy, 1);

    decodeFlush = 1'b1;
    step();
    decodeFlush = 1'b0;
    #1;
    check_eq("dflush_occupancy", occupancy, 0);
    check_eq("dflush_decodeValid", fi.decodeValid, 0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      drive_fetch(1'b1, 32'(4 * i), 32'h1000 + 32'(i));
      step();
    end
    #1;
    check_eq("full_occupancy", occupancy, 4);
    check_eq("full_fetchReady", fi.fetchReady, 0);
    drive_fetch(1'b1, 32'h10, 32'h1004);
    step();
    check_eq("full_fifth_refused", occupancy, 4);
    fi.decodeReady = 1'b1;
    #1;
    check_eq("full_pop_fetchReady", fi.fetchReady, 0);
    check_eq("pop0_pc", fi.instrPCD, 32'h0);
    check_eq("pop0_instr", fi.instrD, 32'h1000);
    step();
    fi.fetchValid = 1'b0;
    #1;
    check_eq("after_pop_occupancy", occupancy, 3);
    check_eq("after_pop_fetchReady", fi.fetchReady, 1);
    for (int i = 1; i < 4; i++) begin
      check_eq("pop_order_pc", fi.instrPCD, 32'(4 * i));
      step();
    end
    check_eq("drained_valid", fi.decodeValid, 0);
    check_eq("drained_occupancy", occupancy, 0);
    check_eq("drained_instrD", fi.instrD, 0);

    // interleaved push/pop across pointer wrap
    n = 0;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h100 + 32'(4 * n);
      drive_fetch(pv[i] != 0, pc, 32'h2000 + 32'(n));
      fi.decodeReady = (rv[i] != 0);
      #1;
      check_eq("wrap_occupancy", occupancy, 64'(mq.size()));
      check_eq("wrap_occ_le4", 64'(occupancy <= 3'd4), 1);
      check_eq("wrap_decodeValid", fi.decodeValid, 64'(mq.size() != 0));
      check_eq("wrap_fetchReady", fi.fetchReady, 64'(mq.size() != 4));
      if (mq.size() != 0) check_eq("wrap_pc", fi.instrPCD, mq[0]);
      do_pop  = (rv[i] != 0) && (mq.size() != 0);
      do_push = (pv[i] != 0) && (mq.size() != 4);
      step();
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(pc);
        n++;
      end
    end
    fi.fetchValid  = 1'b0;
    fi.decodeReady = 1'b1;
    for (int i = 0; i < 4 && mq.size() != 0; i++) begin
      #1;
      check_eq("wrap_drain_pc", fi.instrPCD, mq[0]);
      step();
      void'(mq.pop_front());
    end
    check_eq("wrap_end_valid", fi.decodeValid, 0);
    fi.decodeReady = 1'b0;

    // flush with three queued and a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive_fetch(1'b1, 32'h200 + 32'(4 * i), 32'h3000);
      step();
    end
    check_eq("pre_flush_occupancy", occupancy, 3);
    drive_fetch(1'b1, 32'h2f0, 32'h3333);
    flush       = 1'b1;
    decodeFlush = 1'b1;
    step();
    flush       = 1'b0;
    decodeFlush = 1'b0;
    drive_fetch(1'b0, 32'h0, 32'h0);
    #1;
    check_eq("flush_decodeValid", fi.decodeValid, 0);
    check_eq("flush_occupancy", occupancy, 0);
    check_eq("flush_fetchReady", fi.fetchReady, 1);
    drive_fetch(1'b1, 32'h300, 32'h4444);
    step();
    drive_fetch(1'b0, 32'h0, 32'h0);
    #1;
    check_eq("post_flush_pc", fi.instrPCD, 32'h300);
    check_eq("post_flush_occupancy", occupancy, 1);

    // reset mid-operation with two entries held
    drive_fetch(1'b1, 32'h304, 32'h5555);
    step();
    drive_fetch(1'b0, 32'h0, 32'h0);
    check_eq("pre_rst_occupancy", occupancy, 2);
    globalReset = 1'b0;
    step();
    #1;
    check_eq("midrst_decodeValid", fi.decodeValid, 0);
    check_eq("midrst_instrPCD", fi.instrPCD, 0);
    check_eq("midrst_instrD", fi.instrD, 0);
    check_eq("midrst_occupancy", occupancy, 0);
    check_eq("midrst_fetchReady", fi.fetchReady, 0);
    globalReset = 1'b1;
    drive_fetch(1'b1, 32'h40, 32'h6666);
    step();
    drive_fetch(1'b0, 32'h0, 32'h0);
    #1;
    check_eq("post_rst_pc", fi.instrPCD, 32'h40);
    check_eq("post_rst_occupancy", occupancy, 1);
    fi.decodeReady = 1'b1;
    step();
    check_eq("post_rst_only_entry", fi.decodeValid, 0);

    // empty queue with simultaneous fetch and decode ready
    drive_fetch(1'b1, 32'h20, 32'h7777);
    fi.decodeReady = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("byp_decodeValid", fi.decodeValid, 1);
    check_eq("byp_instrPCD", fi.instrPCD, 32'h20);
    check_eq("byp_occupancy", occupancy, 0);
    step();
    drive_fetch(1'b0, 32'h0, 32'h0);
    fi.decodeReady = 1'b0;
    #1;
    check_eq("byp_after_occupancy", occupancy, 0);
    check_eq("byp_after_valid", fi.decodeValid, 0);
`else
    check_eq("nobyp_same_valid", fi.decodeValid, 0);
    step();
    drive_fetch(1'b0, 32'h0, 32'h0);
    fi.decodeReady = 1'b0;
    #1;
    check_eq("nobyp_next_valid", fi.decodeValid, 1);
    check_eq("nobyp_next_pc", fi.instrPCD, 32'h20);
    check_eq("nobyp_occupancy", occupancy, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between `instrFetchUnit` and `instr_decode`. It absorbs fetch bandwidth while decode is stalled by `freeze` or a full reorder buffer. Each entry carries the fetched instruction together with its branch-prediction context (predicted PC, GHR index, PHT state, redirect flag). The queue is flushed on a commit-time control-flow recovery (`controlFlow[0]`) and on a decode-time early misdirect.

## Interface

Parameters:
- `WIDTH`, default 31: data MSB; datapath is `WIDTH+1` bits.
- `INDEX`, default 7: GHR index MSB.
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `PTR`, default `$clog2(DEPTH)`: pointer width.

Ports:
- `clk`  in  1  — single clock.
- `globalReset`  in  1  — reset; synchronous, active-low.
- `fetchValid`  in  1  — fetch stage presents an entry.
- `fetchReady`  out  1  — queue accepts a push this cycle.
- `instr`, `instrPC`, `predictedPCF`  in  `WIDTH+1` each  — fetched word, its PC, predicted next PC.
- `GHRIndex`  in  `INDEX+1`  — gshare index used for the prediction.
- `PHTState`  in  2  — PHT counter read.
- `redirect`  in  1  — predictor redirected flow.
- `flush`  in  1  — commit-time recovery (`controlFlow[0]`).
- `decodeFlush`  in  1  — decode-stage early misdirect.
- `decodeReady`  in  1  — decode can consume (`!freeze && !fullRob`).
- `decodeValid`  out  1  — head entry valid.
- `instrD`, `instrPCD`, `predictedPCD`  out  `WIDTH+1` each  — head-entry fields.
- `GHRIndexD`  out  `INDEX+1`  — head-entry GHR index.
- `PHTStateD`  out  2  — head-entry PHT state.
- `redirectD`  out  1  — head-entry redirect flag.
- `occupancy`  out  `PTR+1`  — current entry count, 0..`DEPTH`.

## Operation

- Storage: circular array of `DEPTH` entries, with `head`/`tail` pointers (`PTR` bits) and a `count` register (`PTR+1` bits). Pointers wrap modulo `DEPTH` by natural overflow.
- Push: `push = fetchValid && fetchReady`. Writes the entry at `tail`, then `tail+1`.
- `fetchReady = (count != DEPTH)`, derived from registered `count` only. There is no combinational path from `decodeReady`, so a full queue refuses a push even in a cycle where it pops.
- Pop: `pop = decodeValid && decodeReady`, then `head+1`.
- `count` update: `+1` on push only, `-1` on pop only, unchanged when both occur.
- `decodeValid = (count != 0)`. Head-entry outputs read `array[head]` combinationally and are forced to 0 whenever `decodeValid = 0`.
- Flush (`flush || decodeFlush`):
  - `head`, `tail` and `count` all go to 0 at the edge.
  - A push or pop in the same cycle is discarded; flush has priority.
  - Array contents are not cleared.
- `occupancy = count`.

## Timing

- Reset (`globalReset = 0` at edge):
  - `head = tail = count = 0`.
  - While reset is held, `fetchReady = 0` and `decodeValid = 0`.
  - All data outputs, `occupancy` and `decodeValid` read 0 after reset.
  - Reset mid-operation discards all entries, identically to a flush.
- Push-to-decode latency: 1 cycle. An entry pushed at edge N is presented with `decodeValid = 1` in cycle N+1.
- Full: at `count = DEPTH`, `fetchReady = 0`. It rises the cycle after the first pop.
- Empty: `decodeValid = 0`. A `decodeReady` with no valid entry has no effect.
- Wrap-around: FIFO order is preserved across pointer wrap for any push/pop interleaving.
- Flush recovery: `fetchReady = 1` and `decodeValid = 0` in the cycle after a flush. The first post-flush push is visible one cycle later.
- Simultaneous `flush` and `decodeFlush` behave the same as either one alone.

## Configuration

- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count == 0 && fetchValid && decodeReady` and no flush, inputs pass combinationally to the decode outputs with `decodeValid = 1`. The entry is consumed that cycle and not written; pointers and `count` are unchanged.
  - If `decodeReady = 0`, the entry is written normally.
  - `fetchReady` is unchanged.
- Undefined: there is no input-to-output combinational path, and minimum latency is 1 cycle as above.

## Test plan

- Reset, then push A (`instr = 0x00500093`, `instrPC = 0x0`) with `decodeReady = 0`: next cycle `decodeValid = 1`, `instrD = 0x00500093`, `occupancy = 1`.
- Push 4 entries with `decodeReady = 0`: `occupancy = 4` and `fetchReady = 0`. A fifth `fetchValid` is not accepted. Raise `decodeReady`: entries pop in order PC 0x0, 0x4, 0x8, 0xC.
- Run 10 interleaved push/pop cycles crossing the pointer wrap: output PC sequence matches input order. Assert `occupancy` never exceeds 4.
- With 3 entries queued, assert `flush` together with `fetchValid`: next cycle `decodeValid = 0`, `occupancy = 0`, `fetchReady = 1`, and the pushed entry is absent.
- Drive `globalReset = 0` for one edge while holding 2 entries: outputs all read 0 and `occupancy = 0`. A push of PC 0x40 next cycle appears as the only entry.
- With `FETCH_QUEUE_BYPASS_EN`, empty queue, `fetchValid = decodeReady = 1`, `instrPC = 0x20`: `decodeValid = 1` and `instrPCD = 0x20` in the same cycle, and `occupancy` stays 0. Without the macro, the same entry appears one cycle later.
